result_write_master: RTL and testbench

//  Sits between the match engines and result_address_fsm. Buffers match records
//  in a small FIFO and writes each record to result memory over a simple

---
 rtl/result_write_master.sv | 143 ++++++++++++++
 tb/tb_result_write_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_write_master.sv
// Buffers match records in a small FIFO and writes each one to result memory over a
// write-only Avalon-MM style bus, pulsing inc_addr after every completed write.
module result_write_master #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        match_valid,
    input  logic [DATA_W-1:0]           match_data,
    input  logic [ADDR_W-1:0]           addr_in,
    output logic                        inc_addr,
    output logic                        write,
    output logic [ADDR_W-1:0]           address,
    output logic [DATA_W-1:0]           writedata,
    input  logic                        waitrequest,
    input  logic                        clear_overflow,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_INC   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  address_q, address_d;
    logic [DATA_W-1:0]  writedata_q, writedata_d;
    logic               overflow_q, overflow_d;

    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];

    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               drop;

    // Bus-side sequencing: one record per IDLE -> WRITE -> INC round trip.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a path
        // that skips the assignment infers a latch.
        state_d     = state_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d     = ST_WRITE;
                    address_d   = addr_in;
                    writedata_d = fifo_mem[rd_ptr_q];
                end
            end
            ST_WRITE: begin
                if (!waitrequest) begin
                    pop     = 1'b1;
                    state_d = ST_INC;
                end
            end
            ST_INC: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A pop frees a slot in the same edge, so a full FIFO still accepts then.
    always_comb begin
        fifo_full = (count_q == FULL_CNT);
        push      = match_valid && (!fifo_full || pop);
        drop      = match_valid && fifo_full && !pop;

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        // A drop wins over a simultaneous clear so no lost record goes unreported.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            address_q   <= '0;
            writedata_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            overflow_q  <= overflow_d;
        end
    end

    // NOTE: the record storage is deliberately not reset; count_q and the
    // pointers already mark every entry invalid, and unreset RAM maps to memory.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= match_data;
        end
    end

    assign write      = (state_q == ST_WRITE);
    assign inc_addr   = (state_q == ST_INC);
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_result_write_master.sv
// Self-checking bench for result_write_master: cycle vector table, hand-written
// corner sequences and a data/address scoreboard checked on every bus completion.
module tb_result_write_master;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              n_rst;
    logic              match_valid;
    logic [DATA_W-1:0] match_data;
    logic [ADDR_W-1:0] addr_in;
    logic              inc_addr;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic              clear_overflow;
    logic              overflow;
    logic [3:0]        fifo_count;

    result_write_master #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .match_valid   (match_valid),
        .match_data    (match_data),
        .addr_in       (addr_in),
        .inc_addr      (inc_addr),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .waitrequest   (waitrequest),
        .clear_overflow(clear_overflow),
        .overflow      (overflow),
        .fifo_count    (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for result_address_fsm: word slots from addr_base, one per inc_addr.
    logic [31:0] addr_base;
    logic [31:0] slot;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) slot <= 32'd0;
        else if (inc_addr) slot <= slot + 32'd1;
    end
    assign addr_in = addr_base + {slot[29:0], 2'b00};

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int inc_cnt  = 0;
    logic [DATA_W-1:0] sb_q[$];

    typedef struct {
        logic        mv;
        logic [31:0] data;
        logic        wr;
        logic        exp_write;
        logic        exp_inc;
        logic [3:0]  exp_cnt;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; bus completions are scored at the falling edge before
    // the rising edge that retires them.
    task automatic step();
        logic [DATA_W-1:0] exp_d;
        @(negedge clk);
        if (n_rst && write && !waitrequest) begin
            check("sb_has_entry", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                exp_d = sb_q.pop_front();
                check($sformatf("sb_data[%0d]", done_cnt), 64'(writedata), 64'(exp_d));
                check($sformatf("sb_addr[%0d]", done_cnt), 64'(address),
                      64'(addr_base + 32'(4 * done_cnt)));
            end
            done_cnt++;
        end
        if (n_rst && inc_addr) inc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [31:0] base);
        n_rst          = 1'b0;
        match_valid    = 1'b0;
        match_data     = '0;
        waitrequest    = 1'b0;
        clear_overflow = 1'b0;
        addr_base      = base;
        repeat (2) @(posedge clk);
        #1;
        sb_q.delete();
        done_cnt = 0;
        n_rst    = 1'b1;
        check("rst_write", 64'(write), 64'(0));
        check("rst_inc", 64'(inc_addr), 64'(0));
        check("rst_count", 64'(fifo_count), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_address", 64'(address), 64'(0));
        check("rst_writedata", 64'(writedata), 64'(0));
    endtask

    function automatic vec_t mk(input logic mv, input logic [31:0] data, input logic wr,
                                input logic ew, input logic ei, input logic [3:0] ec,
                                input logic [31:0] ea, input logic [31:0] ed);
        vec_t v;
        v.mv = mv; v.data = data; v.wr = wr;
        v.exp_write = ew; v.exp_inc = ei; v.exp_cnt = ec;
        v.exp_addr = ea; v.exp_wdata = ed;
        return v;
    endfunction

    initial begin
        vec_t vecs[12];
        int   inc0;
        int   pushed;

        // Single record with no stall, then a record stalled for four cycles.
        vecs[0]  = mk(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 4'd1, 32'h000, 32'h00000000);
        vecs[1]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 4'd1, 32'h100, 32'hDEADBEEF);
        vecs[2]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd0, 32'h100, 32'hDEADBEEF);
        vecs[3]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0, 32'h100, 32'hDEADBEEF);
        vecs[4]  = mk(1'b1, 32'hCAFE0001, 1'b1, 1'b0, 1'b0, 4'd1, 32'h100, 32'hDEADBEEF);
        vecs[5]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 4'd1, 32'h104, 32'hCAFE0001);
        vecs[6]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 4'd1, 32'h104, 32'hCAFE0001);
        vecs[7]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 4'd1, 32'h104, 32'hCAFE0001);
        vecs[8]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 4'd1, 32'h104, 32'hCAFE0001);
        vecs[9]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 4'd1, 32'h104, 32'hCAFE0001);
        vecs[10] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 4'd0, 32'h104, 32'hCAFE0001);
        vecs[11] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0, 32'h104, 32'hCAFE0001);

        apply_reset(32'h100);
        for (int i = 0; i < 12; i++) begin
            match_valid = vecs[i].mv;
            match_data  = vecs[i].data;
            waitrequest = vecs[i].wr;
            if (vecs[i].mv) sb_q.push_back(vecs[i].data);
            step();
            check($sformatf("vec%0d_write", i), 64'(write), 64'(vecs[i].exp_write));
            check($sformatf("vec%0d_inc", i), 64'(inc_addr), 64'(vecs[i].exp_inc));
            check($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(0));
            check($sformatf("vec%0d_address", i), 64'(address), 64'(vecs[i].exp_addr));
            check($sformatf("vec%0d_writedata", i), 64'(writedata), 64'(vecs[i].exp_wdata));
        end
        check("vec_writes_done", 64'(done_cnt), 64'(2));

        // Fill with the bus stalled: ninth record is dropped.
        apply_reset(32'h2000);
        inc0 = inc_cnt;
        waitrequest = 1'b1;
        for (int k = 0; k < 9; k++) begin
            match_valid = 1'b1;
            match_data  = 32'hA000_0000 + 32'(k);
            if (k < 8) sb_q.push_back(match_data);
            step();
        end
        match_valid = 1'b0;
        check("full_count", 64'(fifo_count), 64'(8));
        check("full_overflow", 64'(overflow), 64'(1));
        check("full_write_held", 64'(write), 64'(1));
        check("full_address", 64'(address), 64'(32'h2000));
        check("full_writedata", 64'(writedata), 64'(32'hA000_0000));

        match_valid    = 1'b1;
        match_data     = 32'h0000_0BAD;
        clear_overflow = 1'b1;
        step();
        match_valid = 1'b0;
        check("clr_vs_drop_overflow", 64'(overflow), 64'(1));
        check("clr_vs_drop_count", 64'(fifo_count), 64'(8));
        step();
        clear_overflow = 1'b0;
        check("clr_overflow", 64'(overflow), 64'(0));

        // Push while full in the cycle the write completes.
        match_valid = 1'b1;
        match_data  = 32'hA000_0008;
        waitrequest = 1'b0;
        sb_q.push_back(match_data);
        step();
        match_valid = 1'b0;
        check("full_pushpop_count", 64'(fifo_count), 64'(8));
        check("full_pushpop_overflow", 64'(overflow), 64'(0));
        check("full_pushpop_inc", 64'(inc_addr), 64'(1));
        check("full_pushpop_write", 64'(write), 64'(0));
        for (int c = 0; c < 100 && done_cnt < 9; c++) step();
        repeat (2) step();
        check("drain_done", 64'(done_cnt), 64'(9));
        check("drain_count", 64'(fifo_count), 64'(0));
        check("drain_inc_total", 64'(inc_cnt - inc0), 64'(9));
        check("drain_sb_empty", 64'(sb_q.size()), 64'(0));

        // Reset asserted mid-write.
        apply_reset(32'h3000);
        match_valid = 1'b1;
        match_data  = 32'h0000_0055;
        waitrequest = 1'b1;
        sb_q.push_back(match_data);
        step();
        match_valid = 1'b0;
        step();
        check("midrst_write_before", 64'(write), 64'(1));
        #2;
        n_rst = 1'b0;
        #1;
        check("midrst_write", 64'(write), 64'(0));
        check("midrst_inc", 64'(inc_addr), 64'(0));
        check("midrst_count", 64'(fifo_count), 64'(0));
        check("midrst_address", 64'(address), 64'(0));
        sb_q.delete();
        done_cnt = 0;
        @(posedge clk);
        #1;
        n_rst       = 1'b1;
        waitrequest = 1'b0;
        inc0 = inc_cnt;
        repeat (5) step();
        check("midrst_no_inc_after", 64'(inc_cnt - inc0), 64'(0));
        check("midrst_no_write_after", 64'(write), 64'(0));

        // Random stall stream of 20 records.
        apply_reset(32'h8000);
        inc0   = inc_cnt;
        pushed = 0;
        for (int cyc = 0; cyc < 3000 && done_cnt < 20; cyc++) begin
            waitrequest = ($urandom_range(2, 0) == 0);
            match_valid = 1'b0;
            if (pushed < 20 && (pushed - done_cnt) < 6 && $urandom_range(1, 0) == 1) begin
                match_valid = 1'b1;
                match_data  = $urandom;
                sb_q.push_back(match_data);
                pushed++;
            end
            step();
            check("stream_count", 64'(fifo_count), 64'(pushed - done_cnt));
        end
        match_valid = 1'b0;
        waitrequest = 1'b0;
        repeat (3) step();
        check("stream_done", 64'(done_cnt), 64'(20));
        check("stream_inc_total", 64'(inc_cnt - inc0), 64'(20));
        check("stream_overflow", 64'(overflow), 64'(0));
        check("stream_sb_empty", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
